// File: rtl/dc_motor_ramp.sv
// Command front-end for one DC motor PWM channel: slew-limited duty ramp plus a
// sequenced direction reversal (ramp to zero, dead-time coast, flip, ramp up).
module dc_motor_ramp #(
  parameter int DUTY_W      = 64,
  parameter int DIV_W       = 16,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic              cmd_coast,
  input  logic [DUTY_W-1:0] cmd_duty,
  input  logic [DUTY_W-1:0] cmd_period,
  input  logic [DUTY_W-1:0] ramp_step,
  input  logic [DIV_W-1:0]  ramp_div,
  output logic              dir,
  output logic              coast,
  output logic [DUTY_W-1:0] pwm_duty,
  output logic [DUTY_W-1:0] pwm_period,
  output logic              busy
);

  localparam logic [2:0] S_COAST = 3'd0;
  localparam logic [2:0] S_RAMP  = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_REV   = 3'd3;
  localparam logic [2:0] S_DEAD  = 3'd4;

  localparam int              DC_W      = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DC_W-1:0] DEAD_LAST = DC_W'(DEAD_CYCLES - 1);

  logic [2:0]        state_q, state_d;
  logic              dir_q, dir_d, coast_q, coast_d, tgt_dir_q, tgt_dir_d;
  logic              ready_q, ready_d, busy_q, busy_d;
  logic [DUTY_W-1:0] duty_q, duty_d, period_q, period_d, target_q, target_d;
  logic [DIV_W-1:0]  presc_q, presc_d;
  logic [DC_W-1:0]   dead_q, dead_d;

  logic              tick, accept, ramp_en;
  logic [DUTY_W-1:0] clamp, toward_tgt, toward_zero;
  logic [DUTY_W:0]   sum;

  always_comb begin
    // >= rather than == keeps the prescaler sane if ramp_div shrinks mid-count
    tick    = (presc_q >= ramp_div);
    presc_d = tick ? '0 : presc_q + DIV_W'(1);
    accept  = cmd_valid && ready_q;
    ramp_en = (ramp_step == '0) || tick;
    clamp   = (cmd_duty < cmd_period) ? cmd_duty : cmd_period;

    // Up-step computed one bit wider so a huge step clamps instead of wrapping
    sum = {1'b0, duty_q} + {1'b0, ramp_step};
    if (ramp_step == '0)
      toward_tgt = target_q;
    else if (duty_q < target_q)
      toward_tgt = (sum >= {1'b0, target_q}) ? target_q : sum[DUTY_W-1:0];
    else if (duty_q > target_q)
      toward_tgt = ((duty_q - target_q) <= ramp_step) ? target_q : duty_q - ramp_step;
    else
      toward_tgt = duty_q;
    toward_zero = ((ramp_step == '0) || (duty_q <= ramp_step)) ? '0 : duty_q - ramp_step;

    state_d   = state_q;
    dir_d     = dir_q;
    coast_d   = coast_q;
    tgt_dir_d = tgt_dir_q;
    duty_d    = duty_q;
    period_d  = period_q;
    target_d  = target_q;
    dead_d    = dead_q;

    if (accept && cmd_coast) begin
      state_d  = S_COAST;
      coast_d  = 1'b1;
      duty_d   = '0;
      target_d = '0;
      period_d = cmd_period;
    end else if (accept) begin
      period_d  = cmd_period;
      target_d  = clamp;
      tgt_dir_d = cmd_dir;
      case (state_q)
        S_COAST: begin
          dir_d   = cmd_dir;
          coast_d = 1'b0;
          state_d = S_RAMP;
        end
        S_RAMP, S_HOLD: begin
          if (cmd_dir != dir_q) begin
            if (duty_q == '0) begin
              state_d = S_DEAD;
              coast_d = 1'b1;
              dead_d  = '0;
            end else begin
              state_d = S_REV;
            end
          end else begin
            state_d = (clamp == duty_q) ? S_HOLD : S_RAMP;
          end
        end
        S_REV:   state_d = (cmd_dir == dir_q) ? S_RAMP : S_REV;
        default: ;
      endcase
    end else begin
      case (state_q)
        S_RAMP: begin
          if (duty_q == target_q) state_d = S_HOLD;
          else if (ramp_en)       duty_d  = toward_tgt;
        end
        S_REV: begin
          if (ramp_en) begin
            duty_d = toward_zero;
            if (toward_zero == '0) begin
              state_d = S_DEAD;
              coast_d = 1'b1;
              dead_d  = '0;
            end
          end
        end
        S_DEAD: begin
          if (dead_q == DEAD_LAST) begin
            state_d = S_RAMP;
            dir_d   = tgt_dir_q;
            coast_d = 1'b0;
            dead_d  = '0;
          end else begin
            dead_d = dead_q + DC_W'(1);
          end
        end
        default: ;
      endcase
    end

    ready_d = (state_d != S_DEAD);
    busy_d  = (duty_d != target_d) || (state_d == S_DEAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_COAST;
      dir_q     <= 1'b0;
      coast_q   <= 1'b1;
      tgt_dir_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      duty_q    <= '0;
      period_q  <= '0;
      target_q  <= '0;
      presc_q   <= '0;
      dead_q    <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      coast_q   <= coast_d;
      tgt_dir_q <= tgt_dir_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      duty_q    <= duty_d;
      period_q  <= period_d;
      target_q  <= target_d;
      presc_q   <= presc_d;
      dead_q    <= dead_d;
    end
  end

  assign cmd_ready  = ready_q;
  assign dir        = dir_q;
  assign coast      = coast_q;
  assign pwm_duty   = duty_q;
  assign pwm_period = period_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dc_motor_ramp.sv
// Bench for dc_motor_ramp: directed scenarios from the command-level rules plus a
// randomized run against a cycle-level behavioural model.
module tb_dc_motor_ramp;
  localparam int DW = 64;
  localparam int VW = 16;
  localparam int DC = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_dir, cmd_coast;
  logic [DW-1:0] cmd_duty, cmd_period, ramp_step;
  logic [VW-1:0] ramp_div;
  logic          dir, coast, busy;
  logic [DW-1:0] pwm_duty, pwm_period;

  int vecs = 0;
  int errs = 0;

  dc_motor_ramp #(.DUTY_W(DW), .DIV_W(VW), .DEAD_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_coast(cmd_coast), .cmd_duty(cmd_duty),
    .cmd_period(cmd_period), .ramp_step(ramp_step), .ramp_div(ramp_div),
    .dir(dir), .coast(coast), .pwm_duty(pwm_duty), .pwm_period(pwm_period),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: RUN merges ramping and holding (duty just chases target).
  localparam int M_COAST = 0, M_RUN = 1, M_REV = 2, M_DEAD = 3;
  int            m_mode, m_dead;
  logic          m_dir, m_coast, m_tdir;
  logic [DW-1:0] m_duty, m_per, m_tgt;
  logic [VW-1:0] m_pre;

  task automatic model_reset();
    m_mode = M_COAST; m_dead = 0; m_dir = 0; m_coast = 1; m_tdir = 0;
    m_duty = '0; m_per = '0; m_tgt = '0; m_pre = '0;
  endtask

  task automatic model_step();
    logic          tk, acc;
    logic [DW:0]   s;
    logic [DW-1:0] t;
    tk    = (m_pre >= ramp_div);
    m_pre = tk ? '0 : m_pre + 1;
    acc   = cmd_valid && (m_mode != M_DEAD);
    t     = (cmd_duty < cmd_period) ? cmd_duty : cmd_period;
    if (acc && cmd_coast) begin
      m_mode = M_COAST; m_coast = 1; m_duty = '0; m_tgt = '0; m_per = cmd_period;
    end else if (acc) begin
      m_per = cmd_period; m_tgt = t; m_tdir = cmd_dir;
      if (m_mode == M_COAST) begin
        m_dir = cmd_dir; m_coast = 0; m_mode = M_RUN;
      end else if (m_mode == M_RUN && cmd_dir != m_dir) begin
        if (m_duty == 0) begin m_mode = M_DEAD; m_coast = 1; m_dead = 0; end
        else m_mode = M_REV;
      end else if (m_mode == M_REV && cmd_dir == m_dir) begin
        m_mode = M_RUN;
      end
    end else if (m_mode == M_RUN) begin
      if (ramp_step == 0) m_duty = m_tgt;
      else if (tk && m_duty < m_tgt) begin
        s = {1'b0, m_duty} + {1'b0, ramp_step};
        m_duty = (s > {1'b0, m_tgt}) ? m_tgt : s[DW-1:0];
      end else if (tk && m_duty > m_tgt)
        m_duty = (m_duty - m_tgt > ramp_step) ? m_duty - ramp_step : m_tgt;
    end else if (m_mode == M_REV) begin
      if (ramp_step == 0 || tk) begin
        m_duty = (ramp_step == 0 || m_duty <= ramp_step) ? '0 : m_duty - ramp_step;
        if (m_duty == 0) begin m_mode = M_DEAD; m_coast = 1; m_dead = 0; end
      end
    end else if (m_mode == M_DEAD) begin
      m_dead++;
      if (m_dead == DC) begin m_mode = M_RUN; m_dir = m_tdir; m_coast = 0; end
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cmd_valid = 0; cmd_dir = 0; cmd_coast = 0; cmd_duty = '0; cmd_period = '0;
    ramp_step = '0; ramp_div = '0;
    rst_n = 0;
    repeat (2) tick_clk();
    rst_n = 1;
    tick_clk();
  endtask

  task automatic send(input logic d, input logic c, input logic [DW-1:0] du,
                      input logic [DW-1:0] pe);
    cmd_valid = 1; cmd_dir = d; cmd_coast = c; cmd_duty = du; cmd_period = pe;
    tick_clk();
    cmd_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vecs++;
    if ({dir, coast, pwm_duty, pwm_period, cmd_ready, busy} !== {1'b0, 1'b1, 64'd0, 64'd0, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL reset: dir=%0b coast=%0b duty=%0d per=%0d rdy=%0b busy=%0b, want 0 1 0 0 1 0",
               dir, coast, pwm_duty, pwm_period, cmd_ready, busy);
    end
  endtask

  task automatic test_ramp_up();
    do_reset();
    ramp_step = 10; ramp_div = 0;
    send(1, 0, 100, 200);
    vecs++;
    if ({dir, coast, pwm_duty, pwm_period} !== {1'b1, 1'b0, 64'd0, 64'd200}) begin
      errs++;
      $display("FAIL ramp_start: dir=%0b coast=%0b duty=%0d per=%0d, want 1 0 0 200",
               dir, coast, pwm_duty, pwm_period);
    end
    for (int k = 1; k <= 10; k++) begin
      tick_clk();
      vecs++;
      if (pwm_duty !== 64'(10 * k) || busy !== (k != 10)) begin
        errs++;
        $display("FAIL ramp_up[%0d]: duty=%0d busy=%0b, want %0d %0b", k, pwm_duty, busy, 10 * k, k != 10);
      end
    end
  endtask

  task automatic test_step_div();
    logic [DW-1:0] exp_v[4];
    logic [DW-1:0] prev;
    int            n, last;
    exp_v[0] = 30; exp_v[1] = 60; exp_v[2] = 90; exp_v[3] = 100;
    do_reset();
    ramp_step = 30; ramp_div = 3;
    send(1, 0, 100, 200);
    prev = pwm_duty; n = 0; last = 0;
    for (int c = 0; c < 30; c++) begin
      tick_clk();
      if (pwm_duty != prev) begin
        vecs++;
        if (n >= 4 || pwm_duty !== exp_v[n] || (n > 0 && c - last != 4)) begin
          errs++;
          $display("FAIL step_div[%0d]: duty=%0d gap=%0d, want %0d gap 4", n, pwm_duty, c - last,
                   (n < 4) ? exp_v[n] : 64'd100);
        end
        n++; last = c; prev = pwm_duty;
      end
    end
    vecs++;
    if (n != 4) begin
      errs++;
      $display("FAIL step_div_count: changes=%0d, want 4", n);
    end
  endtask

  task automatic test_reverse();
    int cnt, b;
    test_ramp_up();
    send(0, 0, 50, 200);
    b = 0;
    while (coast !== 1'b1 && b < 50) begin
      if (dir !== 1'b1) begin
        vecs++; errs++;
        $display("FAIL rev_early_dir: dir=%0b, want 1", dir);
      end
      tick_clk(); b++;
    end
    vecs++;
    if (b != 10 || pwm_duty !== '0) begin
      errs++;
      $display("FAIL rev_rampdown: cycles=%0d duty=%0d, want 10 0", b, pwm_duty);
    end
    cnt = 0;
    while (coast === 1'b1 && cmd_ready === 1'b0 && cnt < 2 * DC + 10) begin
      tick_clk(); cnt++;
    end
    vecs++;
    if (cnt != DC) begin
      errs++;
      $display("FAIL rev_deadtime: cycles=%0d, want %0d", cnt, DC);
    end
    vecs++;
    if ({dir, coast, pwm_duty} !== {1'b0, 1'b0, 64'd0}) begin
      errs++;
      $display("FAIL rev_flip: dir=%0b coast=%0b duty=%0d, want 0 0 0", dir, coast, pwm_duty);
    end
    repeat (5) tick_clk();
    vecs++;
    if (pwm_duty !== 64'd50 || busy !== 1'b0) begin
      errs++;
      $display("FAIL rev_rampup: duty=%0d busy=%0b, want 50 0", pwm_duty, busy);
    end
  endtask

  task automatic test_coast_clamp();
    do_reset();
    ramp_step = 10; ramp_div = 0;
    send(1, 0, 100, 200);
    repeat (3) tick_clk();
    send(1, 1, 100, 200);
    vecs++;
    if ({coast, pwm_duty, busy} !== {1'b1, 64'd0, 1'b0}) begin
      errs++;
      $display("FAIL coast_now: coast=%0b duty=%0d busy=%0b, want 1 0 0", coast, pwm_duty, busy);
    end
    ramp_step = 0;
    send(1, 0, 300, 200);
    tick_clk();
    vecs++;
    if ({coast, pwm_duty, pwm_period, busy} !== {1'b0, 64'd200, 64'd200, 1'b0}) begin
      errs++;
      $display("FAIL clamp: coast=%0b duty=%0d per=%0d busy=%0b, want 0 200 200 0",
               coast, pwm_duty, pwm_period, busy);
    end
  endtask

  task automatic test_overflow_reset();
    logic [DW-1:0] mx;
    mx = '1;
    do_reset();
    ramp_step = mx; ramp_div = 0;
    send(0, 0, mx, mx);
    tick_clk();
    vecs++;
    if (pwm_duty !== mx || busy !== 1'b0) begin
      errs++;
      $display("FAIL overflow: duty=%0h busy=%0b, want %0h 0", pwm_duty, busy, mx);
    end
    ramp_step = 1;
    send(0, 0, 5, mx);
    repeat (2) tick_clk();
    vecs++;
    if (pwm_duty !== mx - 2) begin
      errs++;
      $display("FAIL rampdown_big: duty=%0h, want %0h", pwm_duty, mx - 2);
    end
    #2 rst_n = 0;
    #1;
    vecs++;
    if ({dir, coast, pwm_duty, pwm_period, cmd_ready, busy} !== {1'b0, 1'b1, 64'd0, 64'd0, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL async_reset: dir=%0b coast=%0b duty=%0h per=%0h rdy=%0b busy=%0b",
               dir, coast, pwm_duty, pwm_period, cmd_ready, busy);
    end
    tick_clk();
    rst_n = 1;
    tick_clk();
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) begin
        ramp_step = ($urandom_range(0, 15) == 0) ? '1 : DW'($urandom_range(0, 40));
        ramp_div  = VW'($urandom_range(0, 3));
      end
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_dir   = $urandom_range(0, 1);
      cmd_coast = ($urandom_range(0, 9) == 0);
      cmd_duty   = ($urandom_range(0, 15) == 0) ? {$urandom, $urandom} : DW'($urandom_range(0, 300));
      cmd_period = ($urandom_range(0, 15) == 0) ? {$urandom, $urandom} : DW'($urandom_range(0, 300));
      model_step();
      tick_clk();
      vecs++;
      if ({dir, coast, pwm_duty, pwm_period, cmd_ready, busy} !==
          {m_dir, m_coast, m_duty, m_per, m_mode != M_DEAD, (m_duty != m_tgt) || m_mode == M_DEAD}) begin
        errs++;
        $display("FAIL random[%0d]: dir=%0b coast=%0b duty=%0d per=%0d rdy=%0b busy=%0b, want %0b %0b %0d %0d %0b %0b",
                 c, dir, coast, pwm_duty, pwm_period, cmd_ready, busy, m_dir, m_coast, m_duty, m_per,
                 m_mode != M_DEAD, (m_duty != m_tgt) || m_mode == M_DEAD);
      end
    end
    cmd_valid = 0;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_step_div();
    test_reverse();
    test_coast_clamp();
    test_overflow_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
